seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 86 ++++++++
 tb/tb_seg_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: cycles one digit per SCAN_DIV clocks,
// with a tear-free display register that only updates on frame boundaries.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      disp_reg;
    logic [15:0]      shadow;
    logic             pending;
    logic             step;
    logic             frame_end;
    logic [3:0]       blank;

    assign step      = en && (div_cnt == DIV_LAST);
    assign frame_end = step && (idx == 2'd3);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= 2'd0;
            disp_reg   <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;

            if (en) begin
                if (step) begin
                    div_cnt <= '0;
                    idx     <= idx + 2'd1;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end

            // A write landing on the boundary edge bypasses the shadow so it is not lost for a frame.
            if (frame_end && wr_en) begin
                disp_reg <= wr_data;
                shadow   <= wr_data;
                pending  <= 1'b0;
            end else if (frame_end && pending) begin
                disp_reg <= shadow;
                pending  <= 1'b0;
            end else if (wr_en) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end
        end
    end

    assign digit_idx = idx;

    always_comb begin
        blank = 4'b0000;
        if (blank_lz) begin
            blank[3] = (disp_reg[15:12] == 4'h0);
            blank[2] = blank[3] && (disp_reg[11:8] == 4'h0);
            blank[1] = blank[2] && (disp_reg[7:4] == 4'h0);
        end

        nibble = disp_reg[{idx, 2'b00} +: 4];
        an     = ~(4'b0001 << idx);
        if (!en || blank[idx]) begin
            an = 4'b1111;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4: frame timing, tear-free writes,
// boundary bypass, leading-zero blanking, enable freeze and reset discard.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    seg_scan_ctrl #(.SCAN_DIV(4), .DIV_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] nib_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] an_42  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] nib_42 [4] = '{4'h2, 4'h4, 4'h0, 4'h0};

    initial begin
        reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 16'h0; blank_lz = 1'b0;
        tick(); tick();
        check("rst_an_dis", 16'(an), 16'hF);
        en = 1'b1; #1;
        check("rst_an_en", 16'(an), 16'hE);
        check("rst_idx", 16'(digit_idx), 16'h0);
        check("rst_nib", 16'(nibble), 16'h0);
        check("rst_ft", 16'(frame_tick), 16'h0);
        reset = 1'b0;
        cyc = 0;

        // 1: plain scan, frame_tick in cycle 16
        for (int k = 0; k < 16; k++) begin
            check("t1_an", 16'(an), 16'(an_pat[k/4]));
            check("t1_idx", 16'(digit_idx), 16'(k/4));
            check("t1_nib", 16'(nibble), 16'h0);
            check("t1_ft", 16'(frame_tick), 16'h0);
            tick();
        end
        check("t1_ft16", 16'(frame_tick), 16'h1);
        check("t1_an16", 16'(an), 16'hE);
        tick();
        check("t1_ft17", 16'(frame_tick), 16'h0);

        // 2: mid-frame write waits for boundary
        goto(21);
        wr_en = 1'b1; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        check("t2_pend", 16'(dut.pending), 16'h1);
        while (cyc < 32) begin
            check("t2_hold", 16'(nibble), 16'h0);
            tick();
        end
        check("t2_ft", 16'(frame_tick), 16'h1);
        check("t2_pclr", 16'(dut.pending), 16'h0);
        for (int k = 0; k < 16; k++) begin
            check("t2_nib", 16'(nibble), 16'(nib_1234[k/4]));
            tick();
        end

        // 3: write exactly on the boundary cycle
        goto(63);
        check("t3_pre", 16'(nibble), 16'h1);
        wr_en = 1'b1; wr_data = 16'hABCD;
        tick();
        wr_en = 1'b0;
        check("t3_idx", 16'(digit_idx), 16'h0);
        check("t3_nibD", 16'(nibble), 16'hD);
        check("t3_ft", 16'(frame_tick), 16'h1);
        check("t3_pend", 16'(dut.pending), 16'h0);
        goto(68); check("t3_nibC", 16'(nibble), 16'hC);
        goto(72); check("t3_nibB", 16'(nibble), 16'hB);
        goto(76); check("t3_nibA", 16'(nibble), 16'hA);

        // 4: leading-zero blanking with 0x0042, then 0x0000
        goto(77);
        wr_en = 1'b1; wr_data = 16'h0042;
        tick();
        wr_en = 1'b0; wr_data = 16'h0000;
        goto(80);
        blank_lz = 1'b1; #1;
        for (int k = 0; k < 16; k++) begin
            wr_en = (k == 10);
            check("t4_an", 16'(an), 16'(an_42[k/4]));
            check("t4_nib", 16'(nibble), 16'(nib_42[k/4]));
            if (k == 8) begin
                blank_lz = 1'b0; #1;
                check("t4_live", 16'(an), 16'hB);
                blank_lz = 1'b1; #1;
            end
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("t4_z_an", 16'(an), (k < 4) ? 16'hE : 16'hF);
            check("t4_z_nib", 16'(nibble), 16'h0);
            tick();
        end
        blank_lz = 1'b0;

        // 5: freeze at idx=2, div_cnt=1; write while disabled
        goto(121);
        check("t5_idx", 16'(digit_idx), 16'h2);
        en = 1'b0; wr_en = 1'b1; wr_data = 16'h5555; #1;
        check("t5_an_off", 16'(an), 16'hF);
        for (int k = 0; k < 10; k++) begin
            check("t5_frz_an", 16'(an), 16'hF);
            check("t5_frz_idx", 16'(digit_idx), 16'h2);
            check("t5_frz_ft", 16'(frame_tick), 16'h0);
            tick();
            wr_en = 1'b0;
        end
        check("t5_pend", 16'(dut.pending), 16'h1);
        en = 1'b1; #1;
        check("t5_an_on", 16'(an), 16'hB);
        tick(); check("t5_r1", 16'(digit_idx), 16'h2);
        tick(); check("t5_r2", 16'(digit_idx), 16'h2);
        tick(); check("t5_r3", 16'(digit_idx), 16'h3);
        check("t5_an3", 16'(an), 16'h7);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_old", 16'(nibble), 16'h0);
            check("t5_ft0", 16'(frame_tick), 16'h0);
        end
        tick();
        check("t5_idx0", 16'(digit_idx), 16'h0);
        check("t5_new", 16'(nibble), 16'h5);
        check("t5_ft", 16'(frame_tick), 16'h1);

        // 6: reset with a pending write mid-frame
        repeat (5) tick();
        wr_en = 1'b1; wr_data = 16'h9999;
        tick();
        wr_en = 1'b0;
        tick(); tick();
        check("t6_pend", 16'(dut.pending), 16'h1);
        reset = 1'b1;
        tick();
        check("t6_idx", 16'(digit_idx), 16'h0);
        check("t6_an", 16'(an), 16'hE);
        check("t6_nib", 16'(nibble), 16'h0);
        check("t6_ft", 16'(frame_tick), 16'h0);
        check("t6_pclr", 16'(dut.pending), 16'h0);
        reset = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("t6_nib0", 16'(nibble), 16'h0);
            check("t6_ftk", 16'(frame_tick), (k == 16) ? 16'h1 : 16'h0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
